// File: rtl/fetch_pc_predictor.sv
// IF-stage next-PC generator: direct-mapped BTB with 2-bit counters, ID-stage
// misprediction redirect and saturating branch/mispredict performance counters.
module fetch_pc_predictor #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BTB_ENTRIES = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter bit              PREDICT_EN  = 1'b1,
    parameter int unsigned     CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             res_valid,
    input  logic             res_is_branch,
    input  logic             res_is_jump,
    input  logic [XLEN-1:0]  res_pc,
    input  logic             res_taken,
    input  logic [XLEN-1:0]  res_target,
    input  logic             res_pred_taken,
    input  logic [XLEN-1:0]  res_pred_target,
    input  logic             cnt_clr,
    output logic [XLEN-1:0]  pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    output logic             flush_if,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);

    localparam int unsigned     IDX_W   = $clog2(BTB_ENTRIES);
    localparam int unsigned     TAG_W   = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_INC  = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [XLEN-1:0]  pc_plus4;

    logic             res_ctl;
    logic             taken_eff;
    logic             mis;
    logic [IDX_W-1:0] res_idx;
    logic [TAG_W-1:0] res_tag;
    logic             res_hit;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_next;
    logic             btb_we;
    logic [XLEN-1:0]  pc_next;

    // IF lookup; always reads the pre-update BTB contents
    always_comb begin
        lk_idx      = pc[IDX_W+1:2];
        lk_tag      = pc[XLEN-1:IDX_W+2];
        pc_plus4    = pc + PC_INC;
        lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
        pred_taken  = PREDICT_EN && lk_hit && btb_ctr[lk_idx][1];
        pred_target = lk_hit ? btb_target[lk_idx] : pc_plus4;
    end

    // ID resolution: mispredict detection and BTB update selection
    always_comb begin
        res_ctl   = res_valid && (res_is_branch || res_is_jump);
        taken_eff = res_taken || res_is_jump;
        mis       = res_ctl && ((taken_eff != res_pred_taken) ||
                                (taken_eff && (res_target != res_pred_target)));
        flush_if  = mis;
        res_idx   = res_pc[IDX_W+1:2];
        res_tag   = res_pc[XLEN-1:IDX_W+2];
        res_hit   = btb_valid[res_idx] && (btb_tag[res_idx] == res_tag);
        ctr_cur   = btb_ctr[res_idx];
        btb_we    = res_ctl && PREDICT_EN && (res_hit || taken_eff);
        if (res_is_jump) begin
            ctr_next = 2'b11;
        end else if (!res_hit) begin
            ctr_next = 2'b10;
        end else if (taken_eff) begin
            ctr_next = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
        end else begin
            ctr_next = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
        end
    end

    // Redirect beats stall, stall beats prediction
    always_comb begin
        if (mis) begin
            pc_next = taken_eff ? res_target : res_pc + PC_INC;
        end else if (!pc_write) begin
            pc_next = pc;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end else begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (btb_we) begin
            btb_valid[res_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit
    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag[res_idx] <= res_tag;
            btb_ctr[res_idx] <= ctr_next;
            if (taken_eff) begin
                btb_target[res_idx] <= res_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (cnt_clr) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            if (res_ctl && (br_count != CNT_MAX)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mis && (mis_count != CNT_MAX)) begin
                mis_count <= mis_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench for fetch_pc_predictor: a dynamic-prediction instance driven by
// a vector table, and a static-prediction instance with 2-bit counters.
module tb_fetch_pc_predictor;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dynamic-prediction instance
    logic            pc_write = 1'b1, res_valid = 1'b0, res_is_branch = 1'b0, res_is_jump = 1'b0;
    logic [XLEN-1:0] res_pc = '0, res_target = '0, res_pred_target = '0;
    logic            res_taken = 1'b0, res_pred_taken = 1'b0, cnt_clr = 1'b0;
    logic [XLEN-1:0] pc, pred_target;
    logic            pred_taken, flush_if;
    logic [15:0]     br_count, mis_count;

    fetch_pc_predictor #(
        .XLEN(XLEN), .BTB_ENTRIES(64), .RESET_PC(32'h400), .PREDICT_EN(1'b1), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .res_valid(res_valid),
        .res_is_branch(res_is_branch), .res_is_jump(res_is_jump), .res_pc(res_pc),
        .res_taken(res_taken), .res_target(res_target), .res_pred_taken(res_pred_taken),
        .res_pred_target(res_pred_target), .cnt_clr(cnt_clr), .pc(pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .flush_if(flush_if),
        .br_count(br_count), .mis_count(mis_count)
    );

    // static-prediction instance
    logic            n_pc_write = 1'b1, n_res_valid = 1'b0, n_res_is_branch = 1'b0, n_res_is_jump = 1'b0;
    logic [XLEN-1:0] n_res_pc = '0, n_res_target = '0, n_res_pred_target = '0;
    logic            n_res_taken = 1'b0, n_res_pred_taken = 1'b0, n_cnt_clr = 1'b0;
    logic [XLEN-1:0] n_pc, n_pred_target;
    logic            n_pred_taken, n_flush_if;
    logic [1:0]      n_br_count, n_mis_count;

    fetch_pc_predictor #(
        .XLEN(XLEN), .BTB_ENTRIES(64), .RESET_PC(32'h400), .PREDICT_EN(1'b0), .CNT_W(2)
    ) u_dut_np (
        .clk(clk), .rst(rst), .pc_write(n_pc_write), .res_valid(n_res_valid),
        .res_is_branch(n_res_is_branch), .res_is_jump(n_res_is_jump), .res_pc(n_res_pc),
        .res_taken(n_res_taken), .res_target(n_res_target), .res_pred_taken(n_res_pred_taken),
        .res_pred_target(n_res_pred_target), .cnt_clr(n_cnt_clr), .pc(n_pc),
        .pred_taken(n_pred_taken), .pred_target(n_pred_target), .flush_if(n_flush_if),
        .br_count(n_br_count), .mis_count(n_mis_count)
    );

    typedef struct {
        logic            pw, rv, rb, rj;
        logic [XLEN-1:0] rpc;
        logic            rt;
        logic [XLEN-1:0] rtg;
        logic            rpt;
        logic [XLEN-1:0] rptg;
        logic            clr;
        logic            e_fl, e_pt;
        logic [XLEN-1:0] e_ptg, e_pc;
        logic [15:0]     e_br, e_mis;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic pw, rv, rb, rj, input logic [XLEN-1:0] rpc, input logic rt,
        input logic [XLEN-1:0] rtg, input logic rpt, input logic [XLEN-1:0] rptg,
        input logic clr, input logic e_fl, e_pt, input logic [XLEN-1:0] e_ptg, e_pc,
        input logic [15:0] e_br, e_mis);
        vec_t v;
        v.pw = pw; v.rv = rv; v.rb = rb; v.rj = rj; v.rpc = rpc; v.rt = rt;
        v.rtg = rtg; v.rpt = rpt; v.rptg = rptg; v.clr = clr;
        v.e_fl = e_fl; v.e_pt = e_pt; v.e_ptg = e_ptg; v.e_pc = e_pc;
        v.e_br = e_br; v.e_mis = e_mis;
        return v;
    endfunction

    function automatic vec_t idle(input logic pw, input logic e_pt,
        input logic [XLEN-1:0] e_ptg, e_pc, input logic [15:0] e_br, e_mis);
        return mk(pw, 0, 0, 0, '0, 0, '0, 0, '0, 0, 0, e_pt, e_ptg, e_pc, e_br, e_mis);
    endfunction

    initial begin
        // sequential fetch, then beq 0x40C learns taken -> 0x500 and decays to not-taken
        vecs[0]  = idle(1, 0, 32'h404, 32'h404, 0, 0);
        vecs[1]  = idle(1, 0, 32'h408, 32'h408, 0, 0);
        vecs[2]  = idle(1, 0, 32'h40C, 32'h40C, 0, 0);
        vecs[3]  = mk(1, 1, 1, 0, 32'h40C, 1, 32'h500, 0, 32'h0,   0, 1, 0, 32'h410, 32'h500, 1, 1);
        vecs[4]  = mk(1, 1, 1, 0, 32'h408, 0, 32'h0,   1, 32'h40C, 0, 1, 0, 32'h504, 32'h40C, 2, 2);
        vecs[5]  = mk(1, 1, 1, 0, 32'h40C, 1, 32'h500, 1, 32'h500, 0, 0, 1, 32'h500, 32'h500, 3, 2);
        vecs[6]  = mk(1, 1, 1, 0, 32'h40C, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h504, 32'h504, 4, 2);
        vecs[7]  = mk(1, 1, 1, 0, 32'h40C, 0, 32'h0,   1, 32'h500, 0, 1, 0, 32'h508, 32'h410, 5, 3);
        vecs[8]  = mk(1, 1, 1, 0, 32'h408, 0, 32'h0,   1, 32'h40C, 0, 1, 0, 32'h414, 32'h40C, 6, 4);
        vecs[9]  = idle(1, 0, 32'h500, 32'h410, 6, 4);
        // stall, then a jump mispredict overriding the stall
        vecs[10] = idle(0, 0, 32'h414, 32'h410, 6, 4);
        vecs[11] = idle(0, 0, 32'h414, 32'h410, 6, 4);
        vecs[12] = idle(0, 0, 32'h414, 32'h410, 6, 4);
        vecs[13] = mk(0, 1, 0, 1, 32'h600, 0, 32'h700, 0, 32'h0,   0, 1, 0, 32'h414, 32'h700, 7, 5);
        vecs[14] = idle(1, 0, 32'h704, 32'h704, 7, 5);
        // wrong-target mispredict, jump entry hit, non-control resolution, counter clear
        vecs[15] = mk(1, 1, 1, 0, 32'h40C, 1, 32'h600, 1, 32'h500, 0, 1, 0, 32'h708, 32'h600, 8, 6);
        vecs[16] = idle(1, 1, 32'h700, 32'h700, 8, 6);
        vecs[17] = mk(1, 1, 0, 0, 32'h40C, 1, 32'h123, 0, 32'h0,   0, 0, 0, 32'h704, 32'h704, 8, 6);
        vecs[18] = mk(1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 0, 32'h708, 32'h708, 0, 0);
        // address-space wrap
        vecs[19] = mk(1, 1, 1, 0, 32'hFFFF_FFF8, 0, 32'h0, 1, 32'h0, 0, 1, 0, 32'h70C, 32'hFFFF_FFFC, 1, 1);
        vecs[20] = idle(1, 0, 32'h0, 32'h0, 1, 1);
        vecs[21] = idle(1, 0, 32'h4, 32'h4, 1, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("run_pc", 64'(pc), 64'h40C);

        // asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        chk("rst_pc", 64'(pc), 64'h400);
        chk("rst_np_pc", 64'(n_pc), 64'h400);
        chk("rst_pred", 64'(pred_taken), 64'h0);
        chk("rst_flush", 64'(flush_if), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            pc_write = vecs[i].pw; res_valid = vecs[i].rv; res_is_branch = vecs[i].rb;
            res_is_jump = vecs[i].rj; res_pc = vecs[i].rpc; res_taken = vecs[i].rt;
            res_target = vecs[i].rtg; res_pred_taken = vecs[i].rpt;
            res_pred_target = vecs[i].rptg; cnt_clr = vecs[i].clr;
            #1;
            chk($sformatf("v%0d flush_if", i), 64'(flush_if), 64'(vecs[i].e_fl));
            chk($sformatf("v%0d pred_taken", i), 64'(pred_taken), 64'(vecs[i].e_pt));
            chk($sformatf("v%0d pred_target", i), 64'(pred_target), 64'(vecs[i].e_ptg));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pc", i), 64'(pc), 64'(vecs[i].e_pc));
            chk($sformatf("v%0d br_count", i), 64'(br_count), 64'(vecs[i].e_br));
            chk($sformatf("v%0d mis_count", i), 64'(mis_count), 64'(vecs[i].e_mis));
        end
        res_valid = 1'b0;
        cnt_clr   = 1'b0;

        // static prediction with 2-bit saturating counters
        rst = 1'b1;
        #1;
        chk("np_rst_pc", 64'(n_pc), 64'h400);
        chk("np_rst_br", 64'(n_br_count), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_res_valid = 1'b1; n_res_is_jump = 1'b1; n_res_taken = 1'b1;
            n_res_pc = (i == 0) ? 32'h400 : 32'h800; n_res_target = 32'h800;
            n_res_pred_taken = 1'b0; n_res_pred_target = 32'h0;
            n_cnt_clr = (i == 5);
            #1;
            chk($sformatf("np%0d flush_if", i), 64'(n_flush_if), 64'h1);
            chk($sformatf("np%0d pred_taken", i), 64'(n_pred_taken), 64'h0);
            @(posedge clk);
            #1;
            chk($sformatf("np%0d pc", i), 64'(n_pc), 64'h800);
            chk($sformatf("np%0d br_count", i), 64'(n_br_count),
                (i == 5) ? 64'h0 : (i == 6) ? 64'h1 : (i >= 2) ? 64'h3 : 64'(i + 1));
            chk($sformatf("np%0d mis_count", i), 64'(n_mis_count),
                (i == 5) ? 64'h0 : (i == 6) ? 64'h1 : (i >= 2) ? 64'h3 : 64'(i + 1));
        end
        n_res_valid = 1'b0; n_res_is_jump = 1'b0; n_cnt_clr = 1'b0;
        #1;
        chk("np_idle_pred", 64'(n_pred_taken), 64'h0);
        chk("np_idle_flush", 64'(n_flush_if), 64'h0);
        @(posedge clk);
        #1;
        chk("np_idle_pc", 64'(n_pc), 64'h804);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
